mips_fetch_queue: RTL and testbench

MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/mips_fetch_queue_if.sv | 28 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/mips_fetch_queue.sv | 131 +++++++++++++
 tb/tb_mips_fetch_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types for the instruction fetch queue.
//   fetch_state_e - fetch FSM state (IDLE: no new fetches, RUN: fetching).
//   fetch_entry_t - queue entry {pc, instr} at the default widths; the top
//                   re-declares the same layout at its configured widths and
//                   hands it to fetch_fifo as a type parameter.
package mips_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 32;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_queue_if.sv
// mips_fetch_queue_if: instruction-memory read port and dequeue handshake.
//   imem_req/imem_addr  - read request, word address (fetch queue drives)
//   imem_rdata          - read data, valid one cycle after imem_req
//   deq_valid/deq_instr/deq_pc - queue head (fetch queue drives)
//   deq_ready           - consumer accepts the head
// master: the fetch queue. slave: memory + consumer side.
interface mips_fetch_queue_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               deq_valid;
    logic               deq_ready;
    logic [INSTR_W-1:0] deq_instr;
    logic [PC_W-1:0]    deq_pc;

    modport master (
        output imem_req, imem_addr, deq_valid, deq_instr, deq_pc,
        input  imem_rdata, deq_ready
    );

    modport slave (
        input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc,
        output imem_rdata, deq_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction queue with synchronous flush.
//   clk, rst     - clock, asynchronous active-low reset
//   flush        - empties the queue on this edge (wins over enq)
//   enq/enq_data - write one entry at the tail (caller never enqueues when full)
//   deq          - pop the head (caller only pops when occupancy != 0)
//   head         - current head entry; meaningless while empty
//   occupancy    - number of valid entries, 0..DEPTH
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   enq,
    input  entry_t                 enq_data,
    input  logic                   deq,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        if (enq && !flush)
            mem[wr_ptr] <= enq_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occupancy + OCC_W'(enq) - OCC_W'(deq);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: MIPS instruction prefetch queue.
// Issues sequential word reads to a 1-cycle-latency instruction memory,
// queues returned words with their PC, and hands them to the decoder.
// A redirect flushes the queue, restarts fetch at redirect_pc and toggles
// the epoch so that any response from the old stream is dropped.
//   clk, rst        - clock, asynchronous active-low reset
//   fetch_en        - 1 = new fetches may issue (FSM RUN), 0 = IDLE
//   redirect_valid  - taken jump/branch: flush, restart at redirect_pc
//   bus (master)    - imem read port + dequeue handshake
//   occupancy       - valid entries held
//   fetch_cnt       - enqueued instructions (saturating)
//   flush_cnt       - redirects seen (saturating)
// Build option: define FETCH_PERF_CNT_EN to include the performance counters;
// otherwise fetch_cnt/flush_cnt are tied to 0.
module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    mips_fetch_queue_if.master     bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            flush_cnt
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;     // address of the request now in flight
    logic            epoch;
    logic            req_epoch;  // epoch the in-flight request was issued in
    logic            inflight;   // a response is on imem_rdata this cycle
    logic            enq;
    logic            xfer;
    entry_t          enq_data;
    entry_t          head;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = fetch_en ? RUN : IDLE;
    end

    // FSM: outputs. The in-flight slot is reserved so a response always
    // finds room when it lands.
    always_comb begin
        bus.imem_req = 1'b0;
        if (state == RUN && !redirect_valid &&
            (occupancy + OCC_W'(inflight)) < OCC_W'(DEPTH))
            bus.imem_req = 1'b1;
    end

    assign bus.imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= '0;
            req_pc    <= '0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= bus.imem_req;
            if (bus.imem_req) begin
                req_pc    <= fetch_pc;
                req_epoch <= epoch;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (bus.imem_req) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old stream.
    assign enq      = inflight && (req_epoch == epoch) && !redirect_valid;
    assign xfer     = bus.deq_valid && bus.deq_ready;
    assign enq_data = '{pc: req_pc, instr: bus.imem_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (xfer),
        .head      (head),
        .occupancy (occupancy)
    );

    assign bus.deq_valid = (occupancy != '0);
    assign bus.deq_instr = head.instr;
    assign bus.deq_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (enq && fetch_cnt != '1)            fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect_valid && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb_mips_fetch_queue: directed + randomized bench for mips_fetch_queue.
// Reference model: the dequeued stream must be consecutive word addresses
// starting at 0 after reset and at redirect_pc after each redirect, with
// instr = imem(pc); issued addresses follow the same rule.
module tb_mips_fetch_queue;
    localparam int PC_W    = 12;
    localparam int DEPTH   = 4;
    localparam int INSTR_W = 32;
    localparam int OCC_W   = $clog2(DEPTH) + 1;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_en = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [PC_W-1:0]  redirect_pc = '0;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      fetch_cnt;
    logic [31:0]      flush_cnt;

    mips_fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    mips_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .occupancy      (occupancy),
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] imem_word(input logic [PC_W-1:0] a);
        return INSTR_W'(a) + 32'h100;
    endfunction

    // Instruction memory: data one cycle after the request, garbage otherwise.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? imem_word(bus.imem_addr) : $urandom;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              first_req = -1;
    int              first_dv = -1;
    logic [PC_W-1:0] first_addr = '0;
    logic            prev_req = 1'b0;
    logic [PC_W-1:0] exp_issue = '0;
    logic [PC_W-1:0] exp_deq = '0;
    logic [PC_W-1:0] xq[$];
    logic [PC_W-1:0] tmp_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already set at posedge+1; observe, update model, advance.
    task automatic tick();
        #2;
        cyc++;
        if (rst) begin
            chk("deq_valid_vs_occ", bus.deq_valid, occupancy != 0);
            chk("occ_bound", 64'(occupancy <= DEPTH), 1);
            if (bus.imem_req) begin
                if (first_req < 0) begin
                    first_req  = cyc;
                    first_addr = bus.imem_addr;
                end
                chk("issue_addr", bus.imem_addr, exp_issue);
                chk("issue_not_full", 64'(occupancy < DEPTH), 1);
                exp_issue++;
            end
            if (bus.deq_valid && first_dv < 0) first_dv = cyc;
            if (bus.deq_valid && bus.deq_ready) begin
                chk("deq_pc", bus.deq_pc, exp_deq);
                chk("deq_instr", bus.deq_instr, imem_word(exp_deq));
                xq.push_back(bus.deq_pc);
                exp_deq++;
            end
            if (redirect_valid) begin
                chk("no_issue_on_redirect", bus.imem_req, 0);
                exp_issue = redirect_pc;
                exp_deq   = redirect_pc;
            end
            prev_req = bus.imem_req;
        end else begin
            exp_issue = '0;
            exp_deq   = '0;
            prev_req  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.deq_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_occ", occupancy, 0);
        chk("rst_deq_valid", bus.deq_valid, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_fetch_cnt", fetch_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        @(posedge clk);
        #1;
        tick();
        tick();

        // Streaming start: latency and sequence from PC 0.
        rst = 1'b1;
        fetch_en = 1'b1;
        bus.deq_ready = 1'b1;
        first_req = -1;
        first_dv = -1;
        for (int i = 0; i < 20 && first_dv < 0; i++) tick();
        chk("issue_to_deq_valid", 64'(first_dv - first_req), 2);
        chk("first_issue_pc", first_addr, 0);
        repeat (6) tick();
        chk("seq_len", 64'(xq.size() >= 4), 1);
        for (int i = 0; i < 4 && i < xq.size(); i++) chk("seq_pc", xq[i], i);

        // Back-pressure: fills to DEPTH, stops issuing, drains in order.
        bus.deq_ready = 1'b0;
        repeat (12) tick();
        chk("full_occ", occupancy, DEPTH);
        chk("full_no_req", bus.imem_req, 0);
        bus.deq_ready = 1'b1;
        xq.delete();
        repeat (6) tick();
        chk("drain_len", 64'(xq.size() >= 4), 1);

        // Redirect with a request in flight.
        chk("inflight_before_redirect", prev_req, 1);
        redirect_valid = 1'b1;
        redirect_pc = 12'h040;
        tick();
        redirect_valid = 1'b0;
        xq.delete();
        for (int i = 0; i < 10 && xq.size() == 0; i++) tick();
        tmp_pc = (xq.size() > 0) ? xq[0] : 'x;
        chk("redirect_first_pc", tmp_pc, 12'h040);
        chk("flush_cnt_one", flush_cnt, PERF ? 1 : 0);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        xq.delete();
        for (int i = 0; i < 12 && xq.size() < 3; i++) tick();
        chk("wrap_len", 64'(xq.size() >= 3), 1);
        tmp_pc = (xq.size() > 0) ? xq[0] : 'x;
        chk("wrap_pc0", tmp_pc, 12'hFFE);
        tmp_pc = (xq.size() > 1) ? xq[1] : 'x;
        chk("wrap_pc1", tmp_pc, 12'hFFF);
        tmp_pc = (xq.size() > 2) ? xq[2] : 'x;
        chk("wrap_pc2", tmp_pc, 12'h000);

        // Reset with 3 entries queued.
        bus.deq_ready = 1'b0;
        repeat (8) tick();
        fetch_en = 1'b0;
        repeat (3) tick();
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        tick();
        chk("pre_reset_occ", occupancy, 3);
        rst = 1'b0;
        #1;
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_deq_valid", bus.deq_valid, 0);
        chk("async_rst_imem_req", bus.imem_req, 0);
        tick();
        rst = 1'b1;
        fetch_en = 1'b1;
        first_req = -1;
        for (int i = 0; i < 10 && first_req < 0; i++) tick();
        chk("restart_issued", 64'(first_req >= 0), 1);
        chk("restart_pc", first_addr, 0);
        repeat (10) tick();
        chk("refill_occ", occupancy, DEPTH);
        chk("fetch_cnt_refill", fetch_cnt, PERF ? DEPTH : 0);
        chk("flush_cnt_after_rst", flush_cnt, 0);

        // Randomized traffic against the stream model.
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            bus.deq_ready  = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = PC_W'($urandom);
            tick();
        end

        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        bus.deq_ready = 1'b1;
        repeat (10) tick();
        chk("final_drain_occ", occupancy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
